jt51_noise_gen: RTL and testbench

- Noise-rate and noise-level stage that sits beside the 17-bit noise LFSR.
- It drives the LFSR shift-enable (`lfsr_base`) at the NFRQ-selected rate and consumes the LFSR output bit (`lfsr_out`).
- It scales that bit by the slot-32 envelope attenuation into a signed noise sample, which replaces operator 32 output when NE=1.
- Runs on the operator-slot clock enable: 32 cen pulses per sample.

---
 rtl/jt51_noise_gen.sv | 82 ++++++++
 tb/tb_jt51_noise_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_noise_gen.sv
// jt51_noise_gen
// Noise-rate and noise-level stage for the 17-bit noise LFSR.
// A 5-bit sample counter paces the LFSR shift enable (one shift every
// 32-nfrq samples). The LFSR output bit is latched once per sample at slot 0
// and, at slot 31, scaled by that slot's envelope attenuation into a signed
// noise sample that stands in for operator 32 when noise is enabled.
//
// Ports:
//   rst       async active-high reset
//   clk       clock
//   cen       slot clock enable (32 per sample); all state moves only on cen
//   zero      slot 0 marker (one cen per sample)
//   op31      slot 31 marker (operator 32)
//   ne        noise enable, affects only noise_out
//   nfrq      noise frequency; shift period is 32-nfrq samples
//   eg        envelope attenuation, valid when op31=1 (0 = loudest)
//   lfsr_out  current LFSR output bit
//   lfsr_base LFSR shift enable, high for the cen period of slot 1
//   noise_bit LFSR bit latched for the current sample
//   noise_out signed two's-complement noise sample

module jt51_noise_gen #(
  parameter int NFRQ_W = 5,
  parameter int EG_W   = 10
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  input  logic              zero,
  input  logic              op31,
  input  logic              ne,
  input  logic [NFRQ_W-1:0] nfrq,
  input  logic [EG_W-1:0]   eg,
  input  logic              lfsr_out,
  output logic              lfsr_base,
  output logic              noise_bit,
  output logic [EG_W:0]     noise_out
);

  logic [NFRQ_W-1:0] r_cnt;
  logic              r_base;
  logic              r_bit;
  logic [EG_W:0]     r_noise;

  logic [NFRQ_W-1:0] w_limit;
  logic              w_wrap;

  // Equality compare only: if nfrq moves the limit below the current count,
  // the counter simply runs past the top and wraps with no shift pulse.
  assign w_limit = {NFRQ_W{1'b1}} - nfrq;
  assign w_wrap  = (r_cnt == w_limit);

  // Counter and bit capture advance at slot 0; base is refreshed on every cen
  // so it stays high for exactly the one slot following the wrapping zero.
  // A set noise bit gives +(max-eg); a clear bit gives its one's complement,
  // i.e. -(max-eg)-1, which keeps the waveform symmetric about -0.5.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_base  <= 1'b0;
      r_bit   <= 1'b0;
      r_noise <= '0;
    end else if (cen) begin
      r_base <= zero & w_wrap;
      if (zero) begin
        r_bit <= lfsr_out;
        if (w_wrap) r_cnt <= '0;
        else        r_cnt <= r_cnt + 1'b1;
      end
      if (op31) begin
        if (!ne)        r_noise <= '0;
        else if (r_bit) r_noise <= {1'b0, ~eg};
        else            r_noise <= {1'b1, eg};
      end
    end
  end

  assign lfsr_base = r_base;
  assign noise_bit = r_bit;
  assign noise_out = r_noise;

endmodule

// File: tb/tb_jt51_noise_gen.sv
// Directed testbench for jt51_noise_gen.
module tb_jt51_noise_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        zero;
  logic        op31;
  logic        ne;
  logic [4:0]  nfrq;
  logic [9:0]  eg;
  logic        lfsr_out;
  logic        lfsr_base;
  logic        noise_bit;
  logic [10:0] noise_out;

  int compared   = 0;
  int mismatched = 0;
  int basePulses;
  int baseSlot;

  jt51_noise_gen #(.NFRQ_W(5), .EG_W(10)) dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .zero     (zero),
    .op31     (op31),
    .ne       (ne),
    .nfrq     (nfrq),
    .eg       (eg),
    .lfsr_out (lfsr_out),
    .lfsr_base(lfsr_base),
    .noise_bit(noise_bit),
    .noise_out(noise_out)
  );

  always #5 clk = ~clk;

  // One full sample: 32 cen slots, then one idle cycle. lfsr_out and eg carry
  // the wanted value only in their own slot so wrong capture timing shows up.
  // basePulses/baseSlot report where lfsr_base was seen high in this sample.
  task automatic runSample(input logic bitIn, input logic [9:0] egIn);
    basePulses = 0;
    baseSlot   = -1;
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      if (lfsr_base) begin
        basePulses++;
        baseSlot = s;
      end
      cen      = 1'b1;
      zero     = (s == 0);
      op31     = (s == 31);
      lfsr_out = (s == 0) ? bitIn : ~bitIn;
      eg       = (s == 31) ? egIn : ~egIn;
    end
    @(negedge clk);
    if (lfsr_base) basePulses++;
    cen  = 1'b0;
    zero = 1'b0;
    op31 = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst  = 1'b1;
    cen  = 1'b0;
    zero = 1'b0;
    op31 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b0; zero = 1'b0; op31 = 1'b0;
    ne = 1'b0; nfrq = 5'd0; eg = 10'd0; lfsr_out = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (lfsr_base !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_base: got %b expected 0", lfsr_base); end
    compared++;
    if (noise_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bit: got %b expected 0", noise_bit); end
    compared++;
    if (noise_out !== 11'h000) begin mismatched++; $display("[TB] FAIL reset_out: got %h expected 000", noise_out); end
    rst = 1'b0;
  endtask

  task automatic test_rate_fast();
    nfrq = 5'd31;
    for (int i = 0; i < 3; i++) begin
      runSample(1'b0, 10'd0);
      compared++;
      if (basePulses !== 1) begin mismatched++; $display("[TB] FAIL fast_count[%0d]: got %0d expected 1", i, basePulses); end
      compared++;
      if (baseSlot !== 1) begin mismatched++; $display("[TB] FAIL fast_slot[%0d]: got %0d expected 1", i, baseSlot); end
    end
  endtask

  task automatic test_noise_levels();
    logic        bits [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]  egs  [6] = '{10'd0, 10'd0, 10'd1023, 10'd1023, 10'd100, 10'd100};
    logic [10:0] exps [6] = '{11'h3FF, 11'h400, 11'h000, 11'h7FF, 11'h39B, 11'h464};
    ne = 1'b1;
    for (int i = 0; i < 6; i++) begin
      runSample(bits[i], egs[i]);
      compared++;
      if (noise_bit !== bits[i]) begin mismatched++; $display("[TB] FAIL level_bit[%0d]: got %b expected %b", i, noise_bit, bits[i]); end
      compared++;
      if (noise_out !== exps[i]) begin mismatched++; $display("[TB] FAIL level_out[%0d]: got %h expected %h", i, noise_out, exps[i]); end
    end
  endtask

  task automatic test_ne_toggle();
    ne = 1'b0;
    runSample(1'b1, 10'd0);
    compared++;
    if (noise_out !== 11'h000) begin mismatched++; $display("[TB] FAIL ne_off_out: got %h expected 000", noise_out); end
    compared++;
    if (baseSlot !== 1) begin mismatched++; $display("[TB] FAIL ne_off_base: got slot %0d expected 1", baseSlot); end
    ne = 1'b1;
    runSample(1'b1, 10'd0);
    compared++;
    if (noise_out !== 11'h3FF) begin mismatched++; $display("[TB] FAIL ne_on_out: got %h expected 3ff", noise_out); end
    compared++;
    if (baseSlot !== 1) begin mismatched++; $display("[TB] FAIL ne_on_base: got slot %0d expected 1", baseSlot); end
  endtask

  task automatic test_cen_gate();
    @(negedge clk);
    cen = 1'b0; zero = 1'b1; op31 = 1'b1; lfsr_out = 1'b0; eg = 10'd5; ne = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (noise_out !== 11'h3FF) begin mismatched++; $display("[TB] FAIL cen_out: got %h expected 3ff", noise_out); end
    compared++;
    if (noise_bit !== 1'b1) begin mismatched++; $display("[TB] FAIL cen_bit: got %b expected 1", noise_bit); end
    compared++;
    if (lfsr_base !== 1'b0) begin mismatched++; $display("[TB] FAIL cen_base: got %b expected 0", lfsr_base); end
    zero = 1'b0; op31 = 1'b0;
  endtask

  task automatic test_slow_rate_and_change();
    int total;
    int pulseIdx;
    int pulseSlot;
    int idx [4];
    doReset();
    nfrq = 5'd0;
    ne   = 1'b0;
    total = 0; pulseIdx = -1; pulseSlot = -1;
    for (int i = 0; i < 32; i++) begin
      runSample(1'b0, 10'd0);
      if (basePulses > 0) begin
        total += basePulses;
        pulseIdx  = i;
        pulseSlot = baseSlot;
      end
    end
    compared++;
    if (total !== 1) begin mismatched++; $display("[TB] FAIL slow_count: got %0d expected 1", total); end
    compared++;
    if (pulseIdx !== 31) begin mismatched++; $display("[TB] FAIL slow_index: got %0d expected 31", pulseIdx); end
    compared++;
    if (pulseSlot !== 1) begin mismatched++; $display("[TB] FAIL slow_slot: got %0d expected 1", pulseSlot); end
    // Ten more samples leave the counter at 10, then drop the limit to 3.
    total = 0;
    for (int i = 0; i < 10; i++) begin
      runSample(1'b0, 10'd0);
      total += basePulses;
    end
    compared++;
    if (total !== 0) begin mismatched++; $display("[TB] FAIL pre_change_count: got %0d expected 0", total); end
    nfrq  = 5'd28;
    total = 0;
    for (int k = 0; k < 4; k++) idx[k] = -1;
    for (int i = 0; i < 34; i++) begin
      runSample(1'b0, 10'd0);
      if (basePulses > 0) begin
        if (total < 4) idx[total] = i;
        total += basePulses;
      end
    end
    compared++;
    if (total !== 3) begin mismatched++; $display("[TB] FAIL change_count: got %0d expected 3", total); end
    compared++;
    if (idx[0] !== 25) begin mismatched++; $display("[TB] FAIL change_first: got %0d expected 25", idx[0]); end
    compared++;
    if (idx[1] !== 29) begin mismatched++; $display("[TB] FAIL change_second: got %0d expected 29", idx[1]); end
    compared++;
    if (idx[2] !== 33) begin mismatched++; $display("[TB] FAIL change_third: got %0d expected 33", idx[2]); end
  endtask

  task automatic test_reset_mid();
    int total;
    int pulseIdx;
    doReset();
    nfrq = 5'd14;
    ne   = 1'b1;
    for (int i = 0; i < 17; i++) runSample(1'b1, 10'd0);
    compared++;
    if (noise_out !== 11'h3FF) begin mismatched++; $display("[TB] FAIL mid_pre_out: got %h expected 3ff", noise_out); end
    // Slot 0 of the sample with cnt=17 raises the shift enable.
    @(negedge clk);
    cen = 1'b1; zero = 1'b1; op31 = 1'b0; lfsr_out = 1'b1;
    @(negedge clk);
    cen = 1'b0; zero = 1'b0;
    compared++;
    if (lfsr_base !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_base_high: got %b expected 1", lfsr_base); end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (lfsr_base !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_base: got %b expected 0", lfsr_base); end
    compared++;
    if (noise_bit !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_bit: got %b expected 0", noise_bit); end
    compared++;
    if (noise_out !== 11'h000) begin mismatched++; $display("[TB] FAIL mid_rst_out: got %h expected 000", noise_out); end
    @(negedge clk);
    rst = 1'b0;
    total = 0; pulseIdx = -1;
    for (int i = 0; i < 18; i++) begin
      runSample(1'b1, 10'd0);
      if (basePulses > 0) begin
        total += basePulses;
        pulseIdx = i;
      end
    end
    compared++;
    if (total !== 1) begin mismatched++; $display("[TB] FAIL mid_after_count: got %0d expected 1", total); end
    compared++;
    if (pulseIdx !== 17) begin mismatched++; $display("[TB] FAIL mid_after_index: got %0d expected 17", pulseIdx); end
  endtask

  initial begin
    test_reset();
    test_rate_fast();
    test_noise_levels();
    test_ne_toggle();
    test_cen_gate();
    test_slow_rate_and_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
